// File: rtl/fir_pcpi_controller.sv
// PCPI sequencer for the FIR accelerator: decodes custom-0 FIR instructions,
// drives datapath strobes, times the adder tree and answers the CPU.
module fir_pcpi_controller #(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int N_MAX             = 8,
  parameter int K_MAX             = 512,
  parameter int NUM_ADD_CLK       = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            pcpi_valid,
  input  logic [31:0]                     pcpi_insn,
  input  logic [31:0]                     pcpi_rs1,
  input  logic [31:0]                     pcpi_rs2,
  output logic                            pcpi_wr,
  output logic [31:0]                     pcpi_rd,
  output logic                            pcpi_wait,
  output logic                            pcpi_ready,
  output logic [$clog2(K_MAX):0]          cfg_k,
  output logic [$clog2(N_MAX):0]          cfg_n,
  output logic                            coef_we,
  output logic [$clog2(K_MAX*N_MAX)-1:0]  coef_addr,
  output logic [WIDTH_COEFFICIENT-1:0]    coef_wdata,
  output logic                            smp_push,
  output logic [N_MAX-1:0]                smp_data,
  output logic                            calc_start,
  input  logic [WIDTH_COEFFICIENT-1:0]    acc_result
);
  localparam int KW = $clog2(K_MAX) + 1;
  localparam int NW = $clog2(N_MAX) + 1;
  localparam int AW = $clog2(K_MAX * N_MAX);
  localparam int CW = $clog2(NUM_ADD_CLK + 1);

  typedef enum logic [2:0] {IDLE, EXEC, CALC_WAIT, RESP, COOL} state_t;

  state_t                        state_reg, state_next;
  logic [2:0]                    op_reg, op_next;
  logic [31:0]                   rs1_reg, rs1_next;
  logic [3:0]                    nfield_reg, nfield_next;
  logic [KW-1:0]                 fill_reg, fill_next;
  logic [KW-1:0]                 cfg_k_reg, cfg_k_next;
  logic [NW-1:0]                 cfg_n_reg, cfg_n_next;
  logic [CW-1:0]                 cnt_reg, cnt_next;
  logic                          wr_reg, wr_next, ready_reg, ready_next, wait_reg, wait_next;
  logic [31:0]                   rd_reg, rd_next;
  logic                          coef_we_reg, coef_we_next;
  logic [AW-1:0]                 coef_addr_reg, coef_addr_next;
  logic [WIDTH_COEFFICIENT-1:0]  coef_wdata_reg, coef_wdata_next;
  logic                          push_reg, push_next, calc_reg, calc_next;
  logic [N_MAX-1:0]              smp_data_reg, smp_data_next;

  logic        claimed, cfg_ok, calc_ok;
  logic [9:0]  k_field;
  logic [31:0] product, status_word, result;
  logic [KW-1:0] fill_inc;
  logic        unused_insn_bits;

  assign unused_insn_bits = &{1'b0, pcpi_insn[24:15], pcpi_insn[11:7]};
  assign claimed = pcpi_valid && (pcpi_insn[6:0] == 7'b0001011) &&
                   (pcpi_insn[31:25] == 7'b0000001) && (pcpi_insn[14:12] <= 3'd4);
  assign k_field = rs1_reg[9:0];
  assign cfg_ok  = (k_field != 10'd0) && (32'(k_field) <= 32'(K_MAX)) &&
                   (nfield_reg != 4'd0) && (32'(nfield_reg) <= 32'(N_MAX));
  // Full-width product so that rs1 upper bits take part in the range check
  assign product = 32'(cfg_k_reg) * 32'(cfg_n_reg);
  assign calc_ok = (fill_reg == cfg_k_reg);
  assign fill_inc = (fill_reg >= cfg_k_reg) ? cfg_k_reg : fill_reg + KW'(1);
  assign status_word = (32'(fill_reg) << 16) | ((32'(cfg_n_reg) & 32'hF) << 12) |
                       (32'(cfg_k_reg) & 32'hFFF);

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    rs1_next        = rs1_reg;
    nfield_next     = nfield_reg;
    fill_next       = fill_reg;
    cfg_k_next      = cfg_k_reg;
    cfg_n_next      = cfg_n_reg;
    cnt_next        = cnt_reg;
    wr_next         = 1'b0;
    ready_next      = 1'b0;
    wait_next       = 1'b0;
    rd_next         = 32'd0;
    coef_we_next    = 1'b0;
    coef_addr_next  = '0;
    coef_wdata_next = '0;
    push_next       = 1'b0;
    smp_data_next   = '0;
    calc_next       = 1'b0;
    result          = 32'd0;
    case (state_reg)
      IDLE: begin
        if (claimed) begin
          op_next     = pcpi_insn[14:12];
          rs1_next    = pcpi_rs1;
          nfield_next = pcpi_rs2[3:0];
          state_next  = EXEC;
          wait_next   = 1'b1;
          // Strobes are registered here so they appear exactly in the EXEC cycle
          case (pcpi_insn[14:12])
            3'd1: if (pcpi_rs1 < product) begin
              coef_we_next    = 1'b1;
              coef_addr_next  = pcpi_rs1[AW-1:0];
              coef_wdata_next = WIDTH_COEFFICIENT'(pcpi_rs2);
            end
            3'd2: begin
              push_next     = 1'b1;
              smp_data_next = pcpi_rs1[N_MAX-1:0];
            end
            3'd3: if (calc_ok) begin
              calc_next = 1'b1;
              cnt_next  = CW'(NUM_ADD_CLK);
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        wait_next = 1'b1;
        cnt_next  = cnt_reg - CW'(1);
        case (op_reg)
          3'd0: begin
            if (cfg_ok) begin
              cfg_k_next = KW'(k_field);
              cfg_n_next = NW'(nfield_reg);
              fill_next  = '0;
            end
            result = cfg_ok ? 32'd0 : 32'd1;
          end
          3'd1: result = (rs1_reg < product) ? 32'd0 : 32'd1;
          3'd2: begin
            fill_next = fill_inc;
            result    = 32'(fill_inc);
          end
          3'd3: result = 32'hFFFF_FFFF;
          default: result = status_word;
        endcase
        if (op_reg == 3'd3 && calc_ok) begin
          state_next = CALC_WAIT;
        end else begin
          state_next = RESP;
          ready_next = 1'b1;
          wr_next    = 1'b1;
          rd_next    = result;
        end
      end
      CALC_WAIT: begin
        wait_next = 1'b1;
        if (cnt_reg == '0) begin
          state_next = RESP;
          ready_next = 1'b1;
          wr_next    = 1'b1;
          rd_next    = 32'(acc_result);
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      RESP:    state_next = COOL;
      // The core drops valid one cycle late; ignore it here
      COOL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      op_reg         <= 3'd0;
      rs1_reg        <= 32'd0;
      nfield_reg     <= 4'd0;
      fill_reg       <= '0;
      cfg_k_reg      <= KW'(K_MAX);
      cfg_n_reg      <= NW'(N_MAX);
      cnt_reg        <= '0;
      wr_reg         <= 1'b0;
      ready_reg      <= 1'b0;
      wait_reg       <= 1'b0;
      rd_reg         <= 32'd0;
      coef_we_reg    <= 1'b0;
      coef_addr_reg  <= '0;
      coef_wdata_reg <= '0;
      push_reg       <= 1'b0;
      smp_data_reg   <= '0;
      calc_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      rs1_reg        <= rs1_next;
      nfield_reg     <= nfield_next;
      fill_reg       <= fill_next;
      cfg_k_reg      <= cfg_k_next;
      cfg_n_reg      <= cfg_n_next;
      cnt_reg        <= cnt_next;
      wr_reg         <= wr_next;
      ready_reg      <= ready_next;
      wait_reg       <= wait_next;
      rd_reg         <= rd_next;
      coef_we_reg    <= coef_we_next;
      coef_addr_reg  <= coef_addr_next;
      coef_wdata_reg <= coef_wdata_next;
      push_reg       <= push_next;
      smp_data_reg   <= smp_data_next;
      calc_reg       <= calc_next;
    end
  end

  assign pcpi_wr    = wr_reg;
  assign pcpi_rd    = rd_reg;
  assign pcpi_wait  = wait_reg;
  assign pcpi_ready = ready_reg;
  assign cfg_k      = cfg_k_reg;
  assign cfg_n      = cfg_n_reg;
  assign coef_we    = coef_we_reg;
  assign coef_addr  = coef_addr_reg;
  assign coef_wdata = coef_wdata_reg;
  assign smp_push   = push_reg;
  assign smp_data   = smp_data_reg;
  assign calc_start = calc_reg;
endmodule

// File: tb/tb_fir_pcpi_controller.sv
// Bench for fir_pcpi_controller: per-instruction behavioural model builds a
// cycle-indexed expectation table that a negedge process compares every cycle.
module tb_fir_pcpi_controller;
  localparam int NUM_ADD_CLK = 4;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0, resetn = 1'b0, pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = 32'd0, pcpi_rs1 = 32'd0, pcpi_rs2 = 32'd0;
  logic [31:0] acc_result = 32'd0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, coef_we, smp_push, calc_start;
  logic [31:0] pcpi_rd, coef_wdata;
  logic [9:0]  cfg_k;
  logic [3:0]  cfg_n;
  logic [11:0] coef_addr;
  logic [7:0]  smp_data;

  fir_pcpi_controller #(.WIDTH_COEFFICIENT(32), .N_MAX(8), .K_MAX(512), .NUM_ADD_CLK(NUM_ADD_CLK)) dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .smp_push(smp_push), .smp_data(smp_data), .calc_start(calc_start),
    .acc_result(acc_result));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  bit        exp_wait[DEPTH], exp_ready[DEPTH], exp_we[DEPTH], exp_push[DEPTH], exp_calc[DEPTH];
  bit [31:0] exp_rd[DEPTH], exp_addr[DEPTH], exp_wdata[DEPTH], exp_sdata[DEPTH];

  // Model state (m_*) and the configuration currently visible on cfg_k/cfg_n (v_*)
  int m_k = 512, m_n = 8, m_fill = 0;
  int v_k = 512, v_n = 8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < DEPTH) begin
      chk("wait",  32'(pcpi_wait),  32'(exp_wait[cyc]));
      chk("ready", 32'(pcpi_ready), 32'(exp_ready[cyc]));
      chk("wr",    32'(pcpi_wr),    32'(exp_ready[cyc]));
      chk("coef_we", 32'(coef_we),  32'(exp_we[cyc]));
      chk("smp_push", 32'(smp_push), 32'(exp_push[cyc]));
      chk("calc_start", 32'(calc_start), 32'(exp_calc[cyc]));
      chk("cfg_k", 32'(cfg_k), 32'(v_k));
      chk("cfg_n", 32'(cfg_n), 32'(v_n));
      if (exp_ready[cyc]) chk("rd", pcpi_rd, exp_rd[cyc]);
      if (exp_we[cyc]) begin
        chk("coef_addr", 32'(coef_addr), exp_addr[cyc]);
        chk("coef_wdata", coef_wdata, exp_wdata[cyc]);
      end
      if (exp_push[cyc]) chk("smp_data", 32'(smp_data), exp_sdata[cyc]);
    end
  end

  // Issue one instruction; valid is held until COOL (or into IDLE when hold_extra=1)
  task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] acc_val, input int hold_extra,
                       input int reset_at, output logic [31:0] rd_exp, output int lat);
    int c0, cready, end_c, kf, nf, nk, nn;
    bit claimed, apply_cfg, done;
    @(posedge clk); #1;
    c0 = cyc;
    pcpi_valid = 1'b1;
    pcpi_insn  = {f7, 10'h0, f3, 5'd0, 7'b0001011};
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    claimed    = (f7 == 7'b0000001) && (f3 <= 3'd4);
    rd_exp = 32'd0; cready = c0 + 2; apply_cfg = 1'b0; nk = m_k; nn = m_n;
    if (claimed) begin
      case (f3)
        3'd0: begin
          kf = int'(rs1[9:0]); nf = int'(rs2[3:0]);
          if (kf >= 1 && kf <= 512 && nf >= 1 && nf <= 8) begin
            m_k = kf; m_n = nf; m_fill = 0; nk = kf; nn = nf; apply_cfg = 1'b1;
            rd_exp = 32'd0;
          end else rd_exp = 32'd1;
        end
        3'd1: begin
          if (rs1 < 32'(m_k * m_n)) begin
            exp_we[c0+1] = 1'b1; exp_addr[c0+1] = 32'(rs1[11:0]); exp_wdata[c0+1] = rs2;
            rd_exp = 32'd0;
          end else rd_exp = 32'd1;
        end
        3'd2: begin
          m_fill = (m_fill < m_k) ? m_fill + 1 : m_k;
          exp_push[c0+1] = 1'b1; exp_sdata[c0+1] = 32'(rs1[7:0]);
          rd_exp = 32'(m_fill);
        end
        3'd3: begin
          if (m_fill == m_k) begin
            exp_calc[c0+1] = 1'b1;
            cready = c0 + 2 + NUM_ADD_CLK;
            rd_exp = acc_val;
          end else rd_exp = 32'hFFFF_FFFF;
        end
        default: rd_exp = (32'(m_fill) << 16) | (32'(m_n) << 12) | 32'(m_k);
      endcase
      for (int c = c0 + 1; c <= cready; c++) exp_wait[c] = 1'b1;
      exp_ready[cready] = 1'b1;
      exp_rd[cready] = rd_exp;
    end
    lat   = claimed ? cready - c0 : 0;
    end_c = claimed ? cready + 1 + hold_extra : c0 + 20;
    done  = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk); #1;
      acc_result = (cyc == c0 + 1 + NUM_ADD_CLK) ? acc_val : ~acc_val;
      if (apply_cfg && cyc == c0 + 2) begin v_k = nk; v_n = nn; end
      if (reset_at != 0 && cyc == c0 + reset_at) begin
        resetn = 1'b0; pcpi_valid = 1'b0;
        for (int c = cyc + 1; c < DEPTH; c++) begin
          exp_wait[c] = 0; exp_ready[c] = 0; exp_we[c] = 0; exp_push[c] = 0; exp_calc[c] = 0;
        end
        m_k = 512; m_n = 8; m_fill = 0;
      end else if (reset_at != 0 && cyc == c0 + reset_at + 1) begin
        resetn = 1'b1; v_k = 512; v_n = 8; done = 1'b1;
      end else if (reset_at == 0 && cyc == end_c) begin
        pcpi_valid = 1'b0; done = 1'b1;
      end
    end
    pcpi_valid = 1'b0;
  endtask

  logic [31:0] r;
  int lat;
  initial begin
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 resetn = 1'b1;

    issue(3'd4, 7'h01, 32'd0, 32'd0, 32'd0, 0, 0, r, lat);
    chk("lit_status_reset", r, 32'h0000_8200);
    chk("lit_status_lat", 32'(lat), 32'd2);
    issue(3'd0, 7'h01, 32'd4, 32'd2, 32'd0, 0, 0, r, lat);       chk("lit_cfg_ok", r, 32'd0);
    issue(3'd0, 7'h01, 32'd0, 32'd2, 32'd0, 0, 0, r, lat);       chk("lit_cfg_k0", r, 32'd1);
    issue(3'd0, 7'h01, 32'd513, 32'd2, 32'd0, 0, 0, r, lat);     chk("lit_cfg_k513", r, 32'd1);
    issue(3'd0, 7'h01, 32'd4, 32'd9, 32'd0, 0, 0, r, lat);       chk("lit_cfg_n9", r, 32'd1);
    issue(3'd1, 7'h01, 32'd7, 32'hDEADBEEF, 32'd0, 0, 0, r, lat); chk("lit_wcoef7", r, 32'd0);
    issue(3'd1, 7'h01, 32'd8, 32'h1111_2222, 32'd0, 0, 0, r, lat); chk("lit_wcoef8", r, 32'd1);
    issue(3'd1, 7'h01, 32'h1007, 32'h3333_4444, 32'd0, 0, 0, r, lat); chk("lit_wcoef_hi", r, 32'd1);
    issue(3'd2, 7'h01, 32'h1A5, 32'd0, 32'd0, 0, 0, r, lat);     chk("lit_push1", r, 32'd1);
    issue(3'd2, 7'h01, 32'h03C, 32'd0, 32'd0, 0, 0, r, lat);     chk("lit_push2", r, 32'd2);
    issue(3'd2, 7'h01, 32'h0F3, 32'd0, 32'd0, 0, 0, r, lat);     chk("lit_push3", r, 32'd3);
    issue(3'd3, 7'h01, 32'd0, 32'd0, 32'h12345678, 0, 0, r, lat);
    chk("lit_calc_early", r, 32'hFFFF_FFFF);
    chk("lit_calc_early_lat", 32'(lat), 32'd2);
    issue(3'd2, 7'h01, 32'h055, 32'd0, 32'd0, 0, 0, r, lat);     chk("lit_push4", r, 32'd4);
    issue(3'd2, 7'h01, 32'h0AA, 32'd0, 32'd0, 0, 0, r, lat);     chk("lit_push5_sat", r, 32'd4);
    issue(3'd4, 7'h01, 32'd0, 32'd0, 32'd0, 0, 0, r, lat);       chk("lit_status_k4", r, 32'h0004_2004);
    issue(3'd3, 7'h01, 32'd0, 32'd0, 32'h12345678, 1, 0, r, lat);
    chk("lit_calc_rd", r, 32'h12345678);
    chk("lit_calc_lat", 32'(lat), 32'd6);
    issue(3'd5, 7'h01, 32'd1, 32'd1, 32'd0, 0, 0, r, lat);       chk("lit_unclaimed_f3", 32'(lat), 32'd0);
    issue(3'd0, 7'h00, 32'd2, 32'd1, 32'd0, 0, 0, r, lat);       chk("lit_unclaimed_f7", 32'(lat), 32'd0);
    issue(3'd3, 7'h01, 32'd0, 32'd0, 32'hCAFEF00D, 0, 3, r, lat);
    issue(3'd4, 7'h01, 32'd0, 32'd0, 32'd0, 0, 0, r, lat);
    chk("lit_status_after_reset", r, 32'h0000_8200);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_pcpi_controller.md
Name: fir_pcpi_controller

Overview:
Sequencer between the picorv32 PCPI port and the FIR accelerator datapath (coefficient store, sample shift register, NUM_ADD_CLK-deep adder tree). It decodes the custom-0 FIR instructions and drives the datapath strobes. It times the adder-tree latency and returns results and status to the CPU with correct pcpi_wait/pcpi_ready handshaking. It replaces the ad-hoc decode inside the accelerator so the datapath becomes a pure strobe-driven slave.

Parameters:
WIDTH_COEFFICIENT, 32, coefficient and result width (bits)
N_MAX, 8, max modulator channels; sample word width
K_MAX, 512, max taps per channel
NUM_ADD_CLK, 4, adder-tree latency in cycles from calc_start to valid acc_result (>=1)

Ports:
clk  in  1  core clock
resetn  in  1  reset
pcpi_valid  in  1  PCPI instruction valid
pcpi_insn  in  32  PCPI instruction word
pcpi_rs1  in  32  operand 1
pcpi_rs2  in  32  operand 2
pcpi_wr  out  1  write rd to register file
pcpi_rd  out  32  result
pcpi_wait  out  1  coprocessor busy
pcpi_ready  out  1  instruction complete
cfg_k  out  clog2(K_MAX)+1  active tap count
cfg_n  out  clog2(N_MAX)+1  active channel count
coef_we  out  1  coefficient write strobe
coef_addr  out  clog2(K_MAX*N_MAX)  coefficient index
coef_wdata  out  WIDTH_COEFFICIENT  coefficient value
smp_push  out  1  shift sample into history
smp_data  out  N_MAX  sample bits
calc_start  out  1  launch adder tree
acc_result  in  WIDTH_COEFFICIENT  adder-tree output

Behaviour:
- Single clock clk; reset synchronous, active-low (resetn sampled on rising edge of clk). All outputs registered.
- Reset values: all strobes, pcpi_* outputs and pcpi_rd = 0; cfg_k = K_MAX; cfg_n = N_MAX; fill counter = 0; state IDLE. Reset mid-operation aborts it; no ready is issued. Coefficient contents are not the controller's concern.
- Claimed instruction: pcpi_insn[6:0]=7'b0001011 and [31:25]=7'b0000001, with funct3 [14:12] in 0..4. Other encodings are never claimed: no wait, no ready, CPU traps.
- funct3 ops:
  - 0 CFG: K=rs1[9:0], N=rs2[3:0]. If 1<=K<=K_MAX and 1<=N<=N_MAX: update cfg_k/cfg_n, clear fill, rd=0. Otherwise config is unchanged and rd=1.
  - 1 WCOEF: if rs1 < cfg_k*cfg_n: coef_we with coef_addr=rs1, coef_wdata=rs2, rd=0. Otherwise no strobe, rd=1.
  - 2 PUSH: smp_push, smp_data=rs1[N_MAX-1:0]; fill=min(fill+1,cfg_k); rd=new fill.
  - 3 CALC: if fill==cfg_k: calc_start, wait, rd=acc_result. Otherwise no strobe, rd=32'hFFFFFFFF (immediate).
  - 4 STATUS: rd={fill[15:0], 8'h0, cfg_k-1 low 8 bits... } is not used; rd={fill in [31:16], cfg_n in [15:12], cfg_k in [11:0]}. No side effect.
- FSM: IDLE, EXEC, CALC_WAIT, RESP, COOL.
  - C0, IDLE: claimed pcpi_valid latches op/rs1/rs2; next state EXEC.
  - C1, EXEC: pcpi_wait=1. Strobe (coef_we/smp_push/calc_start) high for exactly this cycle. CFG/fill updates take effect at the end of C1. Valid CALC goes to CALC_WAIT; all others go to RESP.
  - CALC_WAIT: down-counter loaded with NUM_ADD_CLK at C1. acc_result is captured in cycle C1+NUM_ADD_CLK, then state goes to RESP.
  - RESP: pcpi_ready=1, pcpi_wr=1, pcpi_rd valid, pcpi_wait=1 for one cycle only. Next state COOL.
  - COOL: pcpi_valid is ignored for one cycle because the core drops valid late. Next state IDLE.
- Latency: non-CALC ops ready at C2. Valid CALC ready at C2+NUM_ADD_CLK.
- pcpi_wait is high from C1 through the RESP cycle and low otherwise, so it stays well inside the PCPI 16-cycle timeout.
- Overlap: valid is ignored outside IDLE; exactly one strobe pulse per instruction.
- Fill saturates at cfg_k; there is no wrap. Widths: cfg_k*cfg_n is computed at full width before comparison. rs1 upper bits are compared too, so rs1>=2^12 is out of range.

Test Plan:
- Reset then STATUS -> ready at C2, rd=(0<<16)|(8<<12)|512=0x00008200; all strobes stay 0.
- CFG rs1=4, rs2=2 -> rd=0, cfg_k=4, cfg_n=2. CFG rs1=0 -> rd=1, cfg unchanged. CFG rs1=513 -> rd=1.
- WCOEF rs1=7, rs2=0xDEADBEEF with K=4, N=2 -> coef_we high exactly one cycle at C1 with addr 7 and that data, rd=0. WCOEF rs1=8 -> no coef_we, rd=1.
- CALC after 3 PUSHes (rd 1,2,3) -> rd=0xFFFFFFFF at C2, no calc_start. 4th and 5th PUSH -> rd=4, rd=4 (saturated).
- Full CALC with NUM_ADD_CLK=4, acc_result driven 0x12345678 at C5 -> calc_start only at C1, ready+wr at C6 with rd=0x12345678, wait high C1..C6.
- resetn low during CALC_WAIT -> next cycle IDLE, wait=0, no ready. Unclaimed funct3=5 -> never ready. Valid held through COOL -> no second execution.
